// File: rtl/frame_sequencer.sv
// Call/return frame sequencer: pushes and pops 16-bit PC frames on the page-0x01 byte stack.
// Optional overflow/underflow trap enabled by defining FRAME_SEQ_OVERFLOW_TRAP_EN.
module frame_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [7:0]  save_out,
    input  logic [15:0] load_out,
    output logic        loader_select,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        pc_load_en,
    output logic [15:0] pc_load_value,
    output logic        ready,
    output logic        done,
    output logic        fault,
    output logic [7:0]  stack_ptr
);

    typedef enum logic [2:0] {
        StIdle,
        StPushHi,
        StPushLo,
        StPopRdLo,
        StPopRdHi,
        StPopLoad
    } state_t;

    localparam logic [7:0] StackPage = 8'h01;

    state_t state;
    logic   call_blocked;
    logic   ret_blocked;

    // Data paths stay combinational so the cache unit can respond to loader_select in-cycle.
    assign mem_wdata     = mem_we ? save_out : 8'h00;
    assign pc_load_value = pc_load_en ? load_out : 16'h0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            stack_ptr     <= 8'hFF;
            loader_select <= 1'b0;
            mem_addr      <= 16'h0000;
            mem_we        <= 1'b0;
            pc_load_en    <= 1'b0;
            ready         <= 1'b1;
            done          <= 1'b0;
        end else begin
            loader_select <= 1'b0;
            mem_addr      <= 16'h0000;
            mem_we        <= 1'b0;
            pc_load_en    <= 1'b0;
            ready         <= 1'b0;
            done          <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (call_req && !call_blocked) begin
                        state    <= StPushHi;
                        mem_we   <= 1'b1;
                        mem_addr <= {StackPage, stack_ptr};
                    end else if (!call_req && ret_req && !ret_blocked) begin
                        state    <= StPopRdLo;
                        mem_addr <= {StackPage, stack_ptr + 8'd1};
                    end else begin
                        ready <= 1'b1;
                    end
                end
                StPushHi: begin
                    state         <= StPushLo;
                    mem_we        <= 1'b1;
                    loader_select <= 1'b1;
                    mem_addr      <= {StackPage, stack_ptr - 8'd1};
                end
                StPushLo: begin
                    state     <= StIdle;
                    stack_ptr <= stack_ptr - 8'd2;
                    done      <= 1'b1;
                    ready     <= 1'b1;
                end
                StPopRdLo: begin
                    state    <= StPopRdHi;
                    mem_addr <= {StackPage, stack_ptr + 8'd2};
                end
                StPopRdHi: begin
                    // High byte arrives next cycle; cache unit combines it with the latched low byte.
                    state         <= StPopLoad;
                    loader_select <= 1'b1;
                    pc_load_en    <= 1'b1;
                end
                StPopLoad: begin
                    state     <= StIdle;
                    stack_ptr <= stack_ptr + 8'd2;
                    done      <= 1'b1;
                    ready     <= 1'b1;
                end
                default: begin
                    state <= StIdle;
                    ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef FRAME_SEQ_OVERFLOW_TRAP_EN
    logic [7:0] frame_cnt;
    logic       fault_q;

    assign call_blocked = (frame_cnt == 8'd128);
    assign ret_blocked  = (frame_cnt == 8'd0);
    assign fault        = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= 8'd0;
            fault_q   <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            if (state == StIdle) begin
                // call_req has priority, so a blocked call faults even if ret_req is also set.
                fault_q <= call_req ? call_blocked : (ret_req && ret_blocked);
            end
            if (state == StPushLo) begin
                frame_cnt <= frame_cnt + 8'd1;
            end else if (state == StPopLoad) begin
                frame_cnt <= frame_cnt - 8'd1;
            end
        end
    end
`else
    assign call_blocked = 1'b0;
    assign ret_blocked  = 1'b0;
    assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: stimulus queues expected events, a negedge monitor checks them.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        call_req;
    logic        ret_req;
    logic [7:0]  save_out;
    logic [15:0] load_out;
    logic        loader_select;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        pc_load_en;
    logic [15:0] pc_load_value;
    logic        ready;
    logic        done;
    logic        fault;
    logic [7:0]  stack_ptr;

    frame_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .call_req      (call_req),
        .ret_req       (ret_req),
        .save_out      (save_out),
        .load_out      (load_out),
        .loader_select (loader_select),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .pc_load_en    (pc_load_en),
        .pc_load_value (pc_load_value),
        .ready         (ready),
        .done          (done),
        .fault         (fault),
        .stack_ptr     (stack_ptr)
    );

    always #5 clk = ~clk;

    localparam int KWr = 0, KRd = 1, KPc = 2, KDone = 3, KFault = 4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mem[256];
    logic [7:0]  rdata;
    logic [7:0]  lo_latch;
    logic [15:0] cur_pc = 16'h0000;
    logic [7:0]  sp_m;

    // Cache unit and stack memory model (one-cycle read latency).
    assign save_out = loader_select ? cur_pc[7:0] : cur_pc[15:8];
    assign load_out = {rdata, lo_latch};

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_we && mem_addr[15:8] == 8'h01) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        rdata <= mem[mem_addr[7:0]];
        if (!loader_select) lo_latch <= rdata;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_ev(input int k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = 3'(k);
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, required no event at %0t",
                     k, a, d, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != 3'(k) || e.addr !== a || e.data !== d) begin
                n_bad++;
                $display("FAIL event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h at %0t",
                         k, a, d, e.kind, e.addr, e.data, $time);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                observe(KWr, mem_addr, {8'h00, mem_wdata});
            end else begin
                check("wdata_zero_when_idle", {8'h00, mem_wdata}, 16'h0000);
                if (mem_addr != 16'h0000) observe(KRd, mem_addr, 16'h0000);
            end
            if (pc_load_en) observe(KPc, 16'h0000, pc_load_value);
            else check("pc_value_zero_when_idle", pc_load_value, 16'h0000);
            if (done) observe(KDone, 16'h0000, {8'h00, stack_ptr});
            if (fault) observe(KFault, 16'h0000, 16'h0000);
        end
    end

    // Returns at negedge+1 once the scoreboard is drained and the DUT is ready.
    task automatic wait_idle();
        bool_done: begin
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                #1;
                if (exp_q.size() == 0 && ready) begin
                    n_cmp++;
                    disable bool_done;
                end
            end
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d pending events, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        call_req = 1'b0;
        ret_req  = 1'b0;
        exp_q.delete();
        sp_m = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic do_call(input logic [15:0] pc);
        cur_pc = pc;
        expect_ev(KWr, {8'h01, sp_m}, {8'h00, pc[15:8]});
        expect_ev(KWr, {8'h01, sp_m - 8'd1}, {8'h00, pc[7:0]});
        sp_m = sp_m - 8'd2;
        expect_ev(KDone, 16'h0000, {8'h00, sp_m});
        call_req = 1'b1;
        @(posedge clk);
        #1;
        call_req = 1'b0;
        wait_idle();
    endtask

    task automatic do_ret(input logic [15:0] pc);
        expect_ev(KRd, {8'h01, sp_m + 8'd1}, 16'h0000);
        expect_ev(KRd, {8'h01, sp_m + 8'd2}, 16'h0000);
        expect_ev(KPc, 16'h0000, pc);
        sp_m = sp_m + 8'd2;
        expect_ev(KDone, 16'h0000, {8'h00, sp_m});
        ret_req = 1'b1;
        @(posedge clk);
        #1;
        ret_req = 1'b0;
        wait_idle();
    endtask

    task automatic do_faulting(input logic is_call);
        expect_ev(KFault, 16'h0000, 16'h0000);
        call_req = is_call;
        ret_req  = !is_call;
        @(posedge clk);
        #1;
        call_req = 1'b0;
        ret_req  = 1'b0;
        wait_idle();
        check("fault_sp_unchanged", {8'h00, stack_ptr}, {8'h00, sp_m});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_ready", {15'h0, ready}, 16'h0001);
        check("rst_sp", {8'h00, stack_ptr}, 16'h00FF);
        check("rst_we", {15'h0, mem_we}, 16'h0000);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_lsel", {15'h0, loader_select}, 16'h0000);
        check("rst_done", {15'h0, done}, 16'h0000);
        check("rst_fault", {15'h0, fault}, 16'h0000);
        check("rst_pc_en", {15'h0, pc_load_en}, 16'h0000);

        // Two pushes, then two pops in LIFO order.
        do_call(16'h1234);
        check("sp_after_call", {8'h00, stack_ptr}, 16'h00FD);
        do_call(16'hABCD);
        do_ret(16'hABCD);
        do_ret(16'h1234);
        check("sp_after_pops", {8'h00, stack_ptr}, 16'h00FF);

        // Simultaneous call/ret: push only; ret pulse during PUSH_LO is ignored.
        cur_pc = 16'h0F0E;
        expect_ev(KWr, 16'h01FF, 16'h000F);
        expect_ev(KWr, 16'h01FE, 16'h000E);
        expect_ev(KDone, 16'h0000, 16'h00FD);
        sp_m     = 8'hFD;
        call_req = 1'b1;
        ret_req  = 1'b1;
        @(posedge clk);
        #1;
        call_req = 1'b0;
        ret_req  = 1'b0;
        check("busy_not_ready", {15'h0, ready}, 16'h0000);
        @(posedge clk);
        #1;
        ret_req = 1'b1;
        @(posedge clk);
        #1;
        ret_req = 1'b0;
        wait_idle();
        do_ret(16'h0F0E);

        // Reset during PUSH_HI.
        cur_pc   = 16'h7777;
        call_req = 1'b1;
        @(posedge clk);
        #1;
        call_req = 1'b0;
        check("push_hi_we", {15'h0, mem_we}, 16'h0001);
        reset = 1'b1;
        #1;
        check("reset_we_drop", {15'h0, mem_we}, 16'h0000);
        @(posedge clk);
        #1;
        check("reset_ready", {15'h0, ready}, 16'h0001);
        check("reset_sp", {8'h00, stack_ptr}, 16'h00FF);
        exp_q.delete();
        sp_m = 8'hFF;
        @(negedge clk);
        reset = 1'b0;
        #1;

`ifdef FRAME_SEQ_OVERFLOW_TRAP_EN
        do_reset();
        do_faulting(1'b0);
        for (int i = 0; i < 128; i++) do_call(16'h1000 + 16'(i));
        check("full_sp", {8'h00, stack_ptr}, 16'h00FF);
        do_faulting(1'b1);
        do_ret(16'h107F);
`else
        do_reset();
        do_ret(16'h0000);
        check("wrap_sp", {8'h00, stack_ptr}, 16'h0001);
        check("no_fault", {15'h0, fault}, 16'h0000);
        do_call(16'h5AC3);
        check("wrap_call_sp", {8'h00, stack_ptr}, 16'h00FF);
        do_ret(16'h5AC3);
`endif

        repeat (4) @(negedge clk);
        #1;
        check("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
